hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised successor to the fixed forwarding-check and stall pair in the 5-stage core.
- Tracks every instruction issued out of decode through DEPTH post-decode pipeline positions in a shift-register scoreboard.
- From that state it produces per-operand forwarding selects, load-use stalls with configurable load latency, and multi-cycle branch flushes.
- Keeps saturating stall and flush event counters for performance analysis.

Parameters:
- REG_AW, 5, register address width; register 0 is hardwired zero.
- DEPTH, 3, tracked positions after decode; position 1 = EX, 2 = MEM, 3 = WB.
- LOAD_READY, 2, lowest position at which a load's data is forwardable; a load at position < LOAD_READY forces a stall.
- FLUSH_CYCLES, 2, cycles flush stays asserted per taken branch; must be ≥ 1.
- CNTW, 16, width of the performance counters.
- SELW, $clog2(DEPTH+1), derived width of the forwarding selects.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- dec_valid  in  1  decode holds a real instruction.
- dec_rs1  in  REG_AW  decode source register 1.
- dec_rs2  in  REG_AW  decode source register 2.
- dec_use_rs1  in  1  instruction reads rs1.
- dec_use_rs2  in  1  instruction reads rs2.
- dec_rd  in  REG_AW  decode destination register.
- dec_regwrite  in  1  instruction writes rd.
- dec_memread  in  1  instruction is a load.
- branch_taken  in  1  instruction at position 1 resolved taken (redirect).
- stall  out  1  hold IF/ID and insert a NOP into EX.
- flush  out  1  kill IF/ID contents and insert a NOP into EX.
- fwd_sel1  out  SELW  0 = register file; k = forward from the producer at position k.
- fwd_sel2  out  SELW  same encoding, for rs2.
- stall_cnt  out  CNTW  saturating count of stall cycles.
- flush_cnt  out  CNTW  saturating count of accepted taken branches.

Behaviour:
- Scoreboard entry per position p in 1..DEPTH holds {v, rd, wr, ld}.
- Every clock, entry p+1 takes entry p, and the entry at DEPTH retires. The post-decode pipeline never stalls.
- Position 1 loads {dec_valid, dec_rd, dec_regwrite, dec_memread} when dec_valid & ~stall & ~flush; otherwise it loads a bubble (v=0).
- Match rule: position p matches source s when v & wr & rd==s & s!=0 & use_s.
- Youngest match (lowest p) wins. fwd_sel = that p, or 0 if no position matches.
- Hazard when the youngest match for either source has ld=1 and p < LOAD_READY.
- stall = dec_valid & hazard & ~flush & ~reset. Combinational, same cycle.
- While stalled, fwd_sel still reflects the current match; the consumer re-evaluates next cycle against the advanced scoreboard.
- Flush counter rem, width clog2(FLUSH_CYCLES)+1.
  - flush = (branch_taken & rem==0) | (rem != 0), gated low by reset.
  - On an accepted branch (branch_taken & rem==0): rem <= FLUSH_CYCLES-1, and flush_cnt increments.
  - While rem != 0: rem decrements each cycle, and branch_taken is ignored because it comes from a wrong-path bubble.
- Flush and hazard in the same cycle: flush wins, stall=0, no stall count.
- stall_cnt increments on every cycle with stall=1. Both counters saturate at 2^CNTW-1 and never wrap.
- Reset (synchronous, any time including mid-flush or mid-stall):
  - All v=0, rem=0, both counters 0.
  - stall=0, flush=0 during the reset cycle.
  - fwd_sel1 = fwd_sel2 = 0 in the first cycle after reset.
- Latency:
  - stall, flush and fwd_sel are combinational from the current state and inputs.
  - Scoreboard updates are visible in the next cycle.

Test Plan:
- Load-use, defaults. Issue `lw x5`, then `add x6,x5,x1` in the next cycle.
  - Required: stall=1 for exactly 1 cycle with fwd_sel1=1; after the stall, fwd_sel1=2; stall_cnt=1.
- Forward priority. `add x3`, `sub x3`, then a consumer of x3.
  - Required: fwd_sel1=1 (youngest producer). Same sequence with the second producer writing x4: fwd_sel1=2.
- Zero register and unused operands.
  - Producer rd=0 with consumer rs1=0: fwd_sel1=0, no stall.
  - use_rs2=0 with rs2 matching a load at position 1: no stall.
- Branch flush, FLUSH_CYCLES=2.
  - Pulse branch_taken for 1 cycle: flush high for 2 cycles.
  - A second branch_taken in the second cycle is ignored: flush_cnt=1, and positions 1-2 become bubbles.
- Simultaneous flush and load-use hazard: stall=0, flush=1, stall_cnt unchanged.
- Reset and saturation.
  - Assert reset mid-flush: the next cycle has flush=0, all fwd_sel=0, counters 0.
  - With CNTW=4, 20 stall cycles leave stall_cnt=15.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// ============================================================================
// hazard_scoreboard : shift-register hazard scoreboard with operand forwarding
//                     selects, load-use stall, multi-cycle branch flush and
//                     saturating stall/flush counters.
// Revision 1.0
// ============================================================================
`default_nettype none

module hazard_scoreboard #(
  parameter int REG_AW       = 5,
  parameter int DEPTH        = 3,
  parameter int LOAD_READY   = 2,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNTW         = 16,
  parameter int SELW         = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dec_valid,
  input  logic [REG_AW-1:0] dec_rs1,
  input  logic [REG_AW-1:0] dec_rs2,
  input  logic              dec_use_rs1,
  input  logic              dec_use_rs2,
  input  logic [REG_AW-1:0] dec_rd,
  input  logic              dec_regwrite,
  input  logic              dec_memread,
  input  logic              branch_taken,
  output logic              stall,
  output logic              flush,
  output logic [SELW-1:0]   fwd_sel1,
  output logic [SELW-1:0]   fwd_sel2,
  output logic [CNTW-1:0]   stall_cnt,
  output logic [CNTW-1:0]   flush_cnt
);

  localparam int REMW = $clog2(FLUSH_CYCLES) + 1;
  localparam logic [REMW-1:0] c_rem_load = REMW'(FLUSH_CYCLES - 1);

  logic [DEPTH:1]    r_v;
  logic [DEPTH:1]    r_wr;
  logic [DEPTH:1]    r_ld;
  logic [REG_AW-1:0] r_rd [DEPTH:1];
  logic [REMW-1:0]   r_rem;

  logic w_early1;
  logic w_early2;
  logic w_accept;
  logic w_issue;

  // Oldest-to-youngest scan so the youngest matching producer overrides.
  always_comb begin
    fwd_sel1 = '0;
    fwd_sel2 = '0;
    w_early1 = 1'b0;
    w_early2 = 1'b0;
    for (int p = DEPTH; p >= 1; p--) begin
      if (r_v[p] && r_wr[p] && dec_use_rs1 && (dec_rs1 != '0) && (r_rd[p] == dec_rs1)) begin
        fwd_sel1 = SELW'(p);
        w_early1 = r_ld[p] && (p < LOAD_READY);
      end
      if (r_v[p] && r_wr[p] && dec_use_rs2 && (dec_rs2 != '0) && (r_rd[p] == dec_rs2)) begin
        fwd_sel2 = SELW'(p);
        w_early2 = r_ld[p] && (p < LOAD_READY);
      end
    end
  end

  // A branch seen while a flush is pending sits on the wrong path.
  assign w_accept = branch_taken && (r_rem == '0);
  assign flush    = !reset && (w_accept || (r_rem != '0));
  assign stall    = !reset && dec_valid && (w_early1 || w_early2) && !flush;
  assign w_issue  = dec_valid && !stall && !flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_v  <= '0;
      r_wr <= '0;
      r_ld <= '0;
      for (int p = 1; p <= DEPTH; p++) begin
        r_rd[p] <= '0;
      end
    end else begin
      r_v[1]  <= w_issue;
      r_wr[1] <= dec_regwrite;
      r_ld[1] <= dec_memread;
      r_rd[1] <= dec_rd;
      for (int p = 2; p <= DEPTH; p++) begin
        r_v[p]  <= r_v[p-1];
        r_wr[p] <= r_wr[p-1];
        r_ld[p] <= r_ld[p-1];
        r_rd[p] <= r_rd[p-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rem <= '0;
    end else if (w_accept) begin
      r_rem <= c_rem_load;
    end else if (r_rem != '0) begin
      r_rem <= r_rem - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && !(&stall_cnt)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (w_accept && !(&flush_cnt)) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
// ============================================================================
// tb_hazard_scoreboard : self-checking bench for hazard_scoreboard.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       dec_valid = 1'b0;
  logic [4:0] dec_rs1 = '0;
  logic [4:0] dec_rs2 = '0;
  logic       dec_use_rs1 = 1'b0;
  logic       dec_use_rs2 = 1'b0;
  logic [4:0] dec_rd = '0;
  logic       dec_regwrite = 1'b0;
  logic       dec_memread = 1'b0;
  logic       branch_taken = 1'b0;
  logic       stall;
  logic       flush;
  logic [1:0] fwd_sel1;
  logic [1:0] fwd_sel2;
  logic [3:0] stall_cnt;
  logic [3:0] flush_cnt;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
  } dec_t;

  typedef struct packed {
    logic       st;
    logic       fl;
    logic [1:0] f1;
    logic [1:0] f2;
    logic       cf;
  } exp_t;

  exp_t exp_q[$];

  hazard_scoreboard #(
    .REG_AW(5), .DEPTH(3), .LOAD_READY(2), .FLUSH_CYCLES(2), .CNTW(4)
  ) dut (
    .clk(clk), .reset(reset), .dec_valid(dec_valid),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2),
    .dec_rd(dec_rd), .dec_regwrite(dec_regwrite), .dec_memread(dec_memread),
    .branch_taken(branch_taken), .stall(stall), .flush(flush),
    .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic dec_t ins(logic v, logic [4:0] rd, logic rw, logic mr,
                               logic [4:0] rs1, logic u1, logic [4:0] rs2, logic u2);
    ins = '{v: v, rd: rd, rw: rw, mr: mr, rs1: rs1, u1: u1, rs2: rs2, u2: u2};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one decode cycle, queue its expected outputs, compare mid-cycle.
  task automatic step(input string tag, input dec_t d, input logic bt,
                      input logic es, input logic ef, input logic [1:0] e1,
                      input logic [1:0] e2, input logic cf);
    exp_t e;
    dec_valid    = d.v;
    dec_rd       = d.rd;
    dec_regwrite = d.rw;
    dec_memread  = d.mr;
    dec_rs1      = d.rs1;
    dec_use_rs1  = d.u1;
    dec_rs2      = d.rs2;
    dec_use_rs2  = d.u2;
    branch_taken = bt;
    exp_q.push_back('{st: es, fl: ef, f1: e1, f2: e2, cf: cf});
    @(negedge clk);
    e = exp_q.pop_front();
    check_val({tag, ".stall"}, 32'(stall), 32'(e.st));
    check_val({tag, ".flush"}, 32'(flush), 32'(e.fl));
    if (e.cf) begin
      check_val({tag, ".fwd_sel1"}, 32'(fwd_sel1), 32'(e.f1));
      check_val({tag, ".fwd_sel2"}, 32'(fwd_sel2), 32'(e.f2));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnts(input string tag, input int es, input int ef);
    check_val({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(es));
    check_val({tag, ".flush_cnt"}, 32'(flush_cnt), 32'(ef));
  endtask

  task automatic drain();
    repeat (3) step("drain", ins(0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    dec_t ld5;
    @(posedge clk);
    #1;
    // reset cycle: outputs gated low even with a branch and a hazard-looking decode
    step("rst", ins(1, 5, 1, 1, 5, 1, 5, 1), 1'b1, 0, 0, 0, 0, 0);
    reset = 1'b0;
    check_cnts("after_rst", 0, 0);
    step("idle0", ins(0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 0, 0, 0, 0, 1);

    // load-use with default latency
    step("lw5",      ins(1, 5, 1, 1, 0, 0, 0, 0), 1'b0, 0, 0, 0, 0, 1);
    step("lu_stall", ins(1, 6, 1, 0, 5, 1, 1, 1), 1'b0, 1, 0, 1, 0, 1);
    step("lu_go",    ins(1, 6, 1, 0, 5, 1, 1, 1), 1'b0, 0, 0, 2, 0, 1);
    check_cnts("lu", 1, 0);
    drain();

    // forwarding priority
    step("p3a",   ins(1, 3, 1, 0, 0, 0, 0, 0), 1'b0, 0, 0, 0, 0, 1);
    step("p3b",   ins(1, 3, 1, 0, 0, 0, 0, 0), 1'b0, 0, 0, 0, 0, 1);
    step("prio",  ins(1, 7, 1, 0, 3, 1, 0, 0), 1'b0, 0, 0, 1, 0, 1);
    drain();
    step("p3",    ins(1, 3, 1, 0, 0, 0, 0, 0), 1'b0, 0, 0, 0, 0, 1);
    step("p4",    ins(1, 4, 1, 0, 0, 0, 0, 0), 1'b0, 0, 0, 0, 0, 1);
    step("prio2", ins(1, 7, 1, 0, 3, 1, 4, 1), 1'b0, 0, 0, 2, 1, 1);
    drain();

    // zero register and unused operand
    step("ld_x0",  ins(1, 0, 1, 1, 0, 0, 0, 0), 1'b0, 0, 0, 0, 0, 1);
    step("zero",   ins(1, 7, 1, 0, 0, 1, 0, 1), 1'b0, 0, 0, 0, 0, 1);
    drain();
    step("lw9",    ins(1, 9, 1, 1, 0, 0, 0, 0), 1'b0, 0, 0, 0, 0, 1);
    step("unused", ins(1, 7, 1, 0, 1, 1, 9, 0), 1'b0, 0, 0, 0, 0, 1);
    drain();

    // branch flush, second taken pulse on the wrong path is ignored
    step("br_prod",  ins(1, 10, 1, 0, 0, 0, 0, 0),   1'b0, 0, 0, 0, 0, 1);
    step("br_take",  ins(1, 11, 1, 0, 10, 1, 0, 0),  1'b1, 0, 1, 1, 0, 1);
    step("br_ign",   ins(1, 12, 1, 0, 10, 1, 11, 1), 1'b1, 0, 1, 2, 0, 1);
    step("br_after", ins(1, 0, 0, 0, 11, 1, 12, 1),  1'b0, 0, 0, 0, 0, 1);
    check_cnts("br", 1, 1);
    drain();

    // flush beats a simultaneous load-use hazard
    step("lw5b",    ins(1, 5, 1, 1, 0, 0, 0, 0), 1'b0, 0, 0, 0, 0, 1);
    step("fl_haz",  ins(1, 6, 1, 0, 5, 1, 0, 0), 1'b1, 0, 1, 1, 0, 1);
    step("fl_tail", ins(0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 0, 1, 0, 0, 1);
    check_cnts("fl_haz", 1, 2);
    drain();

    // reset in the middle of a flush
    step("p8",     ins(1, 8, 1, 0, 0, 0, 0, 0), 1'b0, 0, 0, 0, 0, 1);
    step("br_mid", ins(1, 9, 1, 0, 8, 1, 0, 0), 1'b1, 0, 1, 1, 0, 1);
    reset = 1'b1;
    step("rst_mid", ins(1, 5, 1, 1, 8, 1, 8, 1), 1'b1, 0, 0, 0, 0, 0);
    reset = 1'b0;
    check_cnts("rst_mid", 0, 0);
    step("post_rst", ins(1, 0, 0, 0, 8, 1, 8, 1), 1'b0, 0, 0, 0, 0, 1);
    drain();

    // stall counter saturation: repeated lw x5,0(x5) stalls every other cycle
    ld5 = ins(1, 5, 1, 1, 5, 1, 0, 0);
    step("sat_first", ld5, 1'b0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      step("sat_stall", ld5, 1'b0, 1, 0, 1, 0, 1);
      check_cnts("sat", (i + 1 > 15) ? 15 : i + 1, 0);
      step("sat_go", ld5, 1'b0, 0, 0, 2, 0, 1);
    end
    check_cnts("sat_end", 15, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
